// File: rtl/sha256_stream_core_if.sv
// sha256_stream_core_if: request/response handshake and word-memory bus of the SHA-256 stream core
interface sha256_stream_core_if #(
  parameter int MAX_WORDS = 64,
  parameter int ADDR_W    = 16
);
  localparam int LW = $clog2(MAX_WORDS + 1);
  logic              start;
  logic [ADDR_W-1:0] msg_addr;
  logic [ADDR_W-1:0] out_addr;
  logic [LW-1:0]     msg_words;
  logic [7:0]        prefix_blocks;
  logic              use_midstate;
  logic [255:0]      midstate_in;
  logic              mode_double;
  logic              busy;
  logic              done;
  logic              error;
  logic [255:0]      digest;
  logic              mem_clk;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_write_data;
  logic [31:0]       mem_read_data;
  modport slave (
    input  start, msg_addr, out_addr, msg_words, prefix_blocks, use_midstate, midstate_in,
           mode_double, mem_read_data,
    output busy, done, error, digest, mem_clk, mem_we, mem_addr, mem_write_data
  );
  modport master (
    output start, msg_addr, out_addr, msg_words, prefix_blocks, use_midstate, midstate_in,
           mode_double, mem_read_data,
    input  busy, done, error, digest, mem_clk, mem_we, mem_addr, mem_write_data
  );
endinterface

// File: rtl/sha256_stream_core.sv
// sha256_stream_core: streaming multi-block SHA-256 with on-the-fly padding, midstate and double hash
module sha256_stream_core #(
  parameter int MAX_WORDS = 64,
  parameter int ADDR_W    = 16,
  parameter bit DOUBLE_EN = 1
) (
  input logic                 clk,
  input logic                 reset_n,
  sha256_stream_core_if.slave bus
);
  localparam int LW = $clog2(MAX_WORDS + 1);
  localparam int BW = $clog2((MAX_WORDS + 18) / 16 + 1);
  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, FINAL, DSETUP, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [BW-1:0]     blk_q, blk_d, nb_q, nb_d;
  logic [ADDR_W-1:0] msg_addr_q, msg_addr_d, out_addr_q, out_addr_d;
  logic [LW-1:0]     mw_q, mw_d;
  logic [63:0]       len_q, len_d;
  logic              dbl_q, dbl_d, pass2_q, pass2_d, err_q, err_d;
  logic [7:0][31:0]  h_q, h_d, v_q, v_d;
  logic [15:0][31:0] w_q, w_d;
  logic [255:0]      digest_q, digest_d;
  logic [31:0]       t1, t2, w_new, pos, last, ld_w;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bs0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bs1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Round datapath (v[7]=a .. v[0]=h, w[0]=W[t]) and the padded word for the current load slot
  always_comb begin
    t1    = v_q[0] + bs1(v_q[3]) + ((v_q[3] & v_q[2]) ^ (~v_q[3] & v_q[1])) + K[cnt_q] + w_q[0];
    t2    = bs0(v_q[7]) + ((v_q[7] & v_q[6]) ^ (v_q[7] & v_q[5]) ^ (v_q[6] & v_q[5]));
    w_new = ss1(w_q[14]) + w_q[9] + ss0(w_q[1]) + w_q[0];
    pos   = 32'(blk_q) * 32'd16 + 32'(cnt_q) - 32'd1;
    last  = 32'(nb_q) * 32'd16 - 32'd1;
    ld_w  = pos < 32'(mw_q) ? bus.mem_read_data :
            pos == 32'(mw_q) ? 32'h8000_0000 :
            pos == last - 32'd1 ? len_q[63:32] :
            pos == last ? len_q[31:0] : '0;
  end

  // Next-state and datapath updates for every phase of a request
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    blk_d      = blk_q;
    nb_d       = nb_q;
    msg_addr_d = msg_addr_q;
    out_addr_d = out_addr_q;
    mw_d       = mw_q;
    len_d      = len_q;
    dbl_d      = dbl_q;
    pass2_d    = pass2_q;
    err_d      = err_q;
    h_d        = h_q;
    v_d        = v_q;
    w_d        = w_q;
    digest_d   = digest_q;
    case (state_q)
      IDLE: if (bus.start) begin
        msg_addr_d = bus.msg_addr;
        out_addr_d = bus.out_addr;
        mw_d       = bus.msg_words;
        nb_d       = BW'((32'(bus.msg_words) + 32'd18) >> 4);
        len_d      = (64'(bus.prefix_blocks) * 64'd16 + 64'(bus.msg_words)) << 5;
        dbl_d      = DOUBLE_EN && bus.mode_double;
        pass2_d    = 1'b0;
        blk_d      = '0;
        cnt_d      = '0;
        h_d        = bus.use_midstate ? bus.midstate_in : IV;
        err_d      = bus.msg_words == '0 || bus.msg_words > LW'(MAX_WORDS);
        state_d    = err_d ? DONE : LOAD;
      end
      LOAD: begin
        if (cnt_q != '0) w_d = {ld_w, w_q[15:1]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd16) begin
          cnt_d   = '0;
          v_d     = h_q;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        v_d   = {t1 + t2, v_q[7:5], v_q[4] + t1, v_q[3:1]};
        w_d   = {w_new, w_q[15:1]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd63) state_d = FINAL;
      end
      FINAL: begin
        for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + v_q[i];
        cnt_d = '0;
        if (blk_q + BW'(1) != nb_q) begin
          blk_d   = blk_q + BW'(1);
          state_d = LOAD;
        end else state_d = dbl_q && !pass2_q ? DSETUP : WRITE;
      end
      DSETUP: begin
        w_d = '0;
        for (int i = 0; i < 8; i++) w_d[i] = h_q[7 - i];
        w_d[8]  = 32'h8000_0000;
        w_d[15] = 32'd256;
        h_d     = IV;
        v_d     = IV;
        pass2_d = 1'b1;
        state_d = COMPUTE;
      end
      WRITE: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd7) begin
          digest_d = h_q;
          state_d  = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      blk_q      <= '0;
      nb_q       <= '0;
      msg_addr_q <= '0;
      out_addr_q <= '0;
      mw_q       <= '0;
      len_q      <= '0;
      dbl_q      <= 1'b0;
      pass2_q    <= 1'b0;
      err_q      <= 1'b0;
      h_q        <= '0;
      v_q        <= '0;
      w_q        <= '0;
      digest_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      blk_q      <= blk_d;
      nb_q       <= nb_d;
      msg_addr_q <= msg_addr_d;
      out_addr_q <= out_addr_d;
      mw_q       <= mw_d;
      len_q      <= len_d;
      dbl_q      <= dbl_d;
      pass2_q    <= pass2_d;
      err_q      <= err_d;
      h_q        <= h_d;
      v_q        <= v_d;
      w_q        <= w_d;
      digest_q   <= digest_d;
    end
  end

  // Status and memory bus decoded from the registered state
  always_comb begin
    bus.mem_clk        = clk;
    bus.busy           = state_q != IDLE && state_q != DONE;
    bus.done           = state_q == DONE;
    bus.error          = state_q == DONE && err_q;
    bus.mem_we         = state_q == WRITE;
    bus.mem_addr       = state_q == LOAD && !cnt_q[4] ? msg_addr_q + ADDR_W'({blk_q, 4'b0}) + ADDR_W'(cnt_q) :
                         state_q == WRITE ? out_addr_q + ADDR_W'(cnt_q) : '0;
    bus.mem_write_data = state_q == WRITE ? h_q[3'd7 - cnt_q[2:0]] : '0;
    bus.digest         = digest_q;
  end
endmodule
